// File: rtl/epd_init_seq.sv
// epd_init_seq: power-up sequencer for the 4.2" v2 e-paper panel.
// Pulses the panel reset pin, streams the init ROM to the SPI byte
// transmitter, and stalls on panel BUSY after SWRESET (0x12) and after the
// last byte. Optional feature macro: EPD_INIT_TIMEOUT_EN adds a BUSY_WAIT
// timeout that ends in the ERR state; without it BUSY_WAIT waits forever
// and error is tied low.
module epd_init_seq #(
  parameter int unsigned ROM_LEN      = 21,
  parameter int unsigned RST_LOW_CYC  = 270000,
  parameter int unsigned RST_WAIT_CYC = 270000,
  parameter int unsigned BUSY_SETTLE  = 64,
  parameter int unsigned BUSY_TIMEOUT = 54000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_cmd,
  input  logic       rom_is_data,
  output logic [7:0] tx_byte,
  output logic       tx_dc,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       tx_idle,
  input  logic       epd_busy,
  output logic       epd_rst_n,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // One shared counter covers every wait, so it is sized for the longest one.
  localparam int unsigned MAX_A   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int unsigned MAX_B   = (BUSY_SETTLE > BUSY_TIMEOUT) ? BUSY_SETTLE : BUSY_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [7:0]       LAST_ADDR   = 8'(ROM_LEN - 1);
  localparam logic [7:0]       CMD_SWRESET = 8'h12;
  localparam logic [CNT_W-1:0] LOW_END     = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_END    = CNT_W'(RST_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_END  = CNT_W'(BUSY_SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_LOW, S_RST_WAIT, S_FETCH, S_SEND,
    S_DRAIN, S_SETTLE, S_BUSY_WAIT, S_DONE, S_ERR
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       rom_addr_q;
  logic [7:0]       tx_byte_q;
  logic             tx_dc_q;
  logic             tx_valid_q;
  logic             epd_rst_n_q;
  logic             busy_q;
  logic             done_q;
  logic             busy_meta_q;
  logic             busy_sync_q;

  // Two-flop synchronizer for the asynchronous panel BUSY pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
    end else begin
      busy_meta_q <= epd_busy;
      busy_sync_q <= busy_meta_q;
    end
  end

`ifdef EPD_INIT_TIMEOUT_EN
  logic error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Sequencer FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rom_addr_q  <= 8'h00;
      tx_byte_q   <= 8'h00;
      tx_dc_q     <= 1'b0;
      tx_valid_q  <= 1'b0;
      epd_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef EPD_INIT_TIMEOUT_EN
      error_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q     <= S_RST_LOW;
            cnt_q       <= '0;
            epd_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
`ifdef EPD_INIT_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
          end
        end
        S_RST_LOW: begin
          if (cnt_q == LOW_END) begin
            state_q     <= S_RST_WAIT;
            cnt_q       <= '0;
            epd_rst_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_RST_WAIT: begin
          if (cnt_q == WAIT_END) begin
            state_q    <= S_FETCH;
            cnt_q      <= '0;
            rom_addr_q <= 8'h00;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_FETCH: begin
          tx_byte_q  <= rom_cmd;
          tx_dc_q    <= rom_is_data;
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            // SWRESET and the final byte both need the panel to go idle.
            if (((tx_byte_q == CMD_SWRESET) && !tx_dc_q) || (rom_addr_q == LAST_ADDR)) begin
              state_q <= S_DRAIN;
            end else begin
              rom_addr_q <= rom_addr_q + 8'd1;
              state_q    <= S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          if (tx_idle) begin
            state_q <= S_SETTLE;
            cnt_q   <= '0;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_END) begin
            state_q <= S_BUSY_WAIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_BUSY_WAIT: begin
          if (!busy_sync_q) begin
            if (rom_addr_q == LAST_ADDR) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              rom_addr_q <= rom_addr_q + 8'd1;
              state_q    <= S_FETCH;
            end
          end else begin
`ifdef EPD_INIT_TIMEOUT_EN
            if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
              state_q     <= S_ERR;
              error_q     <= 1'b1;
              busy_q      <= 1'b0;
              epd_rst_n_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
`else
            cnt_q <= cnt_q;
`endif
          end
        end
        default: begin
          state_q     <= S_IDLE;
          tx_valid_q  <= 1'b0;
          epd_rst_n_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr  = rom_addr_q;
  assign tx_byte   = tx_byte_q;
  assign tx_dc     = tx_dc_q;
  assign tx_valid  = tx_valid_q;
  assign epd_rst_n = epd_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_epd_init_seq.sv
// Bench for epd_init_seq: a ROM-order scoreboard checked every cycle,
// plus directed scenarios for reset pulse, BUSY stall, backpressure,
// timeout (EPD_INIT_TIMEOUT_EN) and reset mid-sequence.
module tb_epd_init_seq;
  localparam int ROM_LEN      = 21;
  localparam int RST_LOW_CYC  = 8;
  localparam int RST_WAIT_CYC = 8;
  localparam int BUSY_SETTLE  = 4;
  localparam int BUSY_TIMEOUT = 100;

  localparam logic [7:0] ROM_B [0:20] = '{
    8'h12, 8'h21, 8'h40, 8'h00, 8'h3C, 8'h05, 8'h11, 8'h03, 8'h44, 8'h00, 8'h31,
    8'h45, 8'h00, 8'h00, 8'h2B, 8'h01, 8'h4E, 8'h00, 8'h4F, 8'h00, 8'h00};
  localparam logic ROM_DC [0:20] = '{
    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] rom_addr, rom_cmd, tx_byte;
  logic rom_is_data, tx_dc, tx_valid, epd_rst_n, busy, done, error;
  logic tx_ready = 1'b1;
  logic tx_idle = 1'b1;
  logic epd_busy = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = 0;
  bit allow_err = 1'b0;

  // scoreboard / model state (owned by the monitor)
  int exp_idx = 0;
  int n_hs = 0;
  bit running = 1'b0;
  bit prev_hold = 1'b0;
  bit prev_rst = 1'b1;
  bit await_first = 1'b0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int last_pulse = 0;
  logic [7:0] hs_byte [0:31];
  logic hs_dc [0:31];
  int hs_cyc [0:31];

  assign rom_cmd     = (rom_addr < 8'd21) ? ROM_B[rom_addr[4:0]] : 8'h00;
  assign rom_is_data = (rom_addr < 8'd21) ? ROM_DC[rom_addr[4:0]] : 1'b0;

  epd_init_seq #(
    .ROM_LEN(ROM_LEN), .RST_LOW_CYC(RST_LOW_CYC), .RST_WAIT_CYC(RST_WAIT_CYC),
    .BUSY_SETTLE(BUSY_SETTLE), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_cmd(rom_cmd), .rom_is_data(rom_is_data),
    .tx_byte(tx_byte), .tx_dc(tx_dc), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_idle(tx_idle), .epd_busy(epd_busy),
    .epd_rst_n(epd_rst_n), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // SPI TX behaviour: always ready, 1-in-3 ready, or random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: begin
          tx_ready = (cyc % 3 == 0);
          tx_idle  = ($urandom_range(0, 3) != 0);
        end
        2: begin
          tx_ready = ($urandom_range(0, 1) == 1);
          tx_idle  = ($urandom_range(0, 2) != 0);
        end
        default: begin
          tx_ready = 1'b1;
          tx_idle  = 1'b1;
        end
      endcase
    end
  end

  // Reference model and per-cycle comparison
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = 0; running = 1'b0; prev_hold = 1'b0; prev_rst = 1'b1; await_first = 1'b0;
    end else begin
      if (running && exp_idx < ROM_LEN && !error)
        chk("busy_during_run", busy == 1'b1 && done == 1'b0, {busy, done}, 2);
      if (!running) begin
        chk("busy_when_idle", busy == 1'b0, busy, 0);
        chk("rst_pin_when_idle", epd_rst_n == 1'b1, epd_rst_n, 1);
      end
      if (done) chk("done_before_all_bytes", exp_idx == ROM_LEN, exp_idx, ROM_LEN);
      if (!allow_err) chk("error_unexpected", error == 1'b0, error, 0);
      chk("rom_addr_range", rom_addr <= 8'(ROM_LEN - 1), rom_addr, ROM_LEN - 1);
      if (prev_hold) chk("valid_dropped_no_handshake", tx_valid == 1'b1, tx_valid, 1);
      if (tx_valid) begin
        chk("byte_count", exp_idx < ROM_LEN, exp_idx, ROM_LEN - 1);
        if (exp_idx < ROM_LEN) begin
          chk("tx_byte", tx_byte == ROM_B[exp_idx], tx_byte, ROM_B[exp_idx]);
          chk("tx_dc", tx_dc == ROM_DC[exp_idx], tx_dc, ROM_DC[exp_idx]);
          chk("rom_addr_vs_byte", rom_addr == 8'(exp_idx), rom_addr, exp_idx);
        end
        if (await_first) begin
          chk("first_valid_latency", cyc - rise_cyc == RST_WAIT_CYC + 1, cyc - rise_cyc, RST_WAIT_CYC + 1);
          await_first = 1'b0;
        end
      end
      if (prev_rst && !epd_rst_n) fall_cyc = cyc;
      if (!prev_rst && epd_rst_n) begin
        last_pulse = cyc - fall_cyc;
        chk("rst_low_len", last_pulse == RST_LOW_CYC, last_pulse, RST_LOW_CYC);
        rise_cyc = cyc;
        await_first = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        if (exp_idx < ROM_LEN) begin
          hs_byte[exp_idx] = tx_byte;
          hs_dc[exp_idx]   = tx_dc;
          hs_cyc[exp_idx]  = cyc;
        end
        exp_idx++;
        n_hs++;
      end
      prev_hold = tx_valid && !tx_ready;
      prev_rst  = epd_rst_n;
      if (running && (done || error)) begin
        running = 1'b0;
      end else if (!running && start) begin
        running = 1'b1; exp_idx = 0; n_hs = 0;
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", done == 1'b1, done, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rom_addr", rom_addr == 8'h00, rom_addr, 0);
    chk("rst_tx_byte", tx_byte == 8'h00, tx_byte, 0);
    chk("rst_tx_dc", tx_dc == 1'b0, tx_dc, 0);
    chk("rst_tx_valid", tx_valid == 1'b0, tx_valid, 0);
    chk("rst_epd_rst_n", epd_rst_n == 1'b1, epd_rst_n, 1);
    chk("rst_busy", busy == 1'b0, busy, 0);
    chk("rst_done", done == 1'b0, done, 0);
    chk("rst_error", error == 1'b0, error, 0);
  endtask

  initial begin
    int k, viol, t_hs, t_err;
    bit seen;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    rst_n = 1'b1;

    // full run, ready/idle always high
    mode = 0;
    do_start();
    wait_done(2000);
    chk("full_hs_count", n_hs == 21, n_hs, 21);
    chk("byte0", hs_byte[0] == 8'h12 && hs_dc[0] == 1'b0, {hs_byte[0], 7'd0, hs_dc[0]}, 16'h1200);
    chk("byte2", hs_byte[2] == 8'h40 && hs_dc[2] == 1'b1, {hs_byte[2], 7'd0, hs_dc[2]}, 16'h4001);
    chk("byte20", hs_byte[20] == 8'h00 && hs_dc[20] == 1'b1, {hs_byte[20], 7'd0, hs_dc[20]}, 16'h0001);
    chk("rst_pulse_len", last_pulse == 8, last_pulse, 8);
    for (int i = 2; i < 21; i++)
      chk("throughput_gap", hs_cyc[i] - hs_cyc[i-1] == 2, hs_cyc[i] - hs_cyc[i-1], 2);

    // BUSY held after SWRESET
    do_start();
    k = 0;
    while (!(tx_valid && tx_ready && tx_byte == 8'h12) && k < 200) begin @(negedge clk); k++; end
    chk("swreset_seen", tx_valid && tx_ready && tx_byte == 8'h12, tx_byte, 8'h12);
    epd_busy = 1'b1;
    viol = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (tx_valid) viol++; end
    chk("no_valid_while_busy", viol == 0, viol, 0);
    epd_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin @(negedge clk); if (tx_valid) seen = 1'b1; end
    chk("byte1_after_busy", seen && tx_byte == 8'h21, tx_byte, 8'h21);
    wait_done(2000);

    // backpressure: ready 1 clock in 3, random idle
    mode = 1;
    do_start();
    wait_done(5000);
    chk("bp_hs_count", n_hs == 21, n_hs, 21);

    // random ready/idle/busy, plus an ignored start mid-run
    mode = 2;
    do_start();
    k = 0;
    while (!done && k < 8000) begin
      @(negedge clk);
      #2;
      epd_busy = ($urandom_range(0, 9) < 2);
      start = (k == 40);
      k++;
    end
    epd_busy = 1'b0; start = 1'b0;
    chk("rand_done", done == 1'b1, done, 1);
    chk("rand_hs_count", n_hs == 21, n_hs, 21);

    // BUSY stuck high
    mode = 0;
    epd_busy = 1'b1;
`ifdef EPD_INIT_TIMEOUT_EN
    allow_err = 1'b1;
    do_start();
    k = 0;
    while (!error && k < 500) begin @(negedge clk); k++; end
    t_err = cyc;
    t_hs = hs_cyc[0];
    chk("timeout_error", error == 1'b1, error, 1);
    chk("timeout_no_done", done == 1'b0, done, 0);
    chk("timeout_window", (t_err - t_hs >= BUSY_TIMEOUT + BUSY_SETTLE) && (t_err - t_hs <= BUSY_TIMEOUT + BUSY_SETTLE + 4),
        t_err - t_hs, BUSY_TIMEOUT + BUSY_SETTLE + 2);
    epd_busy = 1'b0;
    do_start();
    @(negedge clk);
    chk("error_cleared", error == 1'b0 && busy == 1'b1, {error, busy}, 1);
    wait_done(2000);
    allow_err = 1'b0;
`else
    do_start();
    viol = 0;
    t_err = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (error) t_err++;
      if (!busy) viol++;
    end
    chk("stuck_error_low", t_err == 0, t_err, 0);
    chk("stuck_busy_high", viol == 0, viol, 0);
    epd_busy = 1'b0;
    wait_done(2000);
`endif

    // async reset in the middle of byte 5
    mode = 1;
    do_start();
    k = 0;
    while (!(tx_valid && rom_addr == 8'd5) && k < 500) begin @(negedge clk); k++; end
    chk("reached_byte5", tx_valid && rom_addr == 8'd5, rom_addr, 5);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 0;
    do_start();
    wait_done(2000);
    chk("replay_byte0", hs_byte[0] == 8'h12 && hs_dc[0] == 1'b0, hs_byte[0], 8'h12);
    chk("replay_hs_count", n_hs == 21, n_hs, 21);
    chk("replay_pulse", last_pulse == 8, last_pulse, 8);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1, "bench time limit");
  end
endmodule
